bus_slave_port: RTL and testbench

//  Bit-serial slave endpoint for one sN_* port of the bus interconnect; the responder side of the master port protocol.

---
 rtl/bus_slave_port.sv | 143 ++++++++++++++
 tb/tb_bus_slave_port.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_port.sv
// bus_slave_port: bit-serial slave endpoint with local memory; define SLAVE_RD_WAIT_EN to add RD_WAIT read wait cycles per word
module bus_slave_port #(
  parameter int ADDR_W = 12,
  parameter int MEM_ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int BURST_W = 8,
  parameter int RD_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic master_valid,
  input  logic master_ready,
  input  logic rx_address,
  input  logic rx_burst_num,
  input  logic rx_data,
  input  logic write_en,
  input  logic read_en,
  output logic tx_data,
  output logic slave_valid,
  output logic slave_ready,
  output logic trans_done
);
  localparam int CW = $clog2(ADDR_W + 1);
  localparam int DCW = $clog2(DATA_W);
`ifdef SLAVE_RD_WAIT_EN
  localparam int WCW = $clog2(RD_WAIT + 1);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RLOAD, RWAIT, RDATA, DONE} state_t;
  logic [WCW-1:0] wcnt;
`else
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RLOAD, RDATA, DONE} state_t;
`endif
  state_t state;
  logic [CW-1:0] cnt;
  logic [DCW-1:0] bcnt;
  logic [MEM_ADDR_W-1:0] addr;
  logic [BURST_W-1:0] burst;
  logic [DATA_W-1:0] wsr, rsr;
  logic dir_wr, wr_pend;
  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];
  always_ff @(posedge clk)
    if (wr_pend) mem[addr] <= wsr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      addr <= '0;
      burst <= '0;
      wsr <= '0;
      rsr <= '0;
      dir_wr <= 1'b0;
      wr_pend <= 1'b0;
      tx_data <= 1'b0;
      slave_valid <= 1'b0;
      slave_ready <= 1'b0;
      trans_done <= 1'b0;
`ifdef SLAVE_RD_WAIT_EN
      wcnt <= '0;
`endif
    end else begin
      wr_pend <= 1'b0;
      trans_done <= 1'b0;
      if (wr_pend) addr <= addr + 1'b1;
      case (state)
        IDLE: begin
          slave_ready <= 1'b1;
          if (slave_ready && master_valid && (write_en ^ read_en)) begin
            state <= ADDR;
            slave_ready <= 1'b0;
            dir_wr <= write_en;
            cnt <= CW'(1);
            addr <= MEM_ADDR_W'(rx_address);
            burst <= BURST_W'(rx_burst_num);
          end
        end
        ADDR:
          if (cnt == CW'(ADDR_W)) begin
            state <= dir_wr ? WDATA : RLOAD;
            slave_ready <= dir_wr;
            burst <= burst == '0 ? BURST_W'(1) : burst;
            bcnt <= '0;
          end else if (master_valid) begin
            cnt <= cnt + 1'b1;
            addr <= {addr[MEM_ADDR_W-2:0], rx_address};
            if (cnt < CW'(BURST_W)) burst <= {burst[BURST_W-2:0], rx_burst_num};
          end
        WDATA:
          if (master_valid) begin
            wsr <= {wsr[DATA_W-2:0], rx_data};
            bcnt <= bcnt + 1'b1;
            if (bcnt == DCW'(DATA_W - 1)) begin
              wr_pend <= 1'b1;
              bcnt <= '0;
              burst <= burst - 1'b1;
              if (burst == BURST_W'(1)) begin
                state <= DONE;
                trans_done <= 1'b1;
                slave_ready <= 1'b0;
              end
            end
          end
        RLOAD: begin
          rsr <= mem[addr];
`ifdef SLAVE_RD_WAIT_EN
          state <= RWAIT;
          wcnt <= '0;
`else
          state <= RDATA;
          slave_valid <= 1'b1;
          tx_data <= mem[addr][DATA_W-1];
`endif
        end
`ifdef SLAVE_RD_WAIT_EN
        RWAIT:
          if (wcnt == WCW'(RD_WAIT - 1)) begin
            state <= RDATA;
            slave_valid <= 1'b1;
            tx_data <= rsr[DATA_W-1];
          end else wcnt <= wcnt + 1'b1;
`endif
        RDATA:
          if (master_ready) begin
            rsr <= {rsr[DATA_W-2:0], rsr[DATA_W-1]};
            tx_data <= rsr[DATA_W-2];
            bcnt <= bcnt + 1'b1;
            if (bcnt == DCW'(DATA_W - 1)) begin
              bcnt <= '0;
              slave_valid <= 1'b0;
              tx_data <= 1'b0;
              addr <= addr + 1'b1;
              burst <= burst - 1'b1;
              state <= burst == BURST_W'(1) ? DONE : RLOAD;
              trans_done <= burst == BURST_W'(1);
            end
          end
        DONE: begin
          slave_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bus_slave_port.sv
// tb_bus_slave_port: scoreboard bench for bus_slave_port against a word-level memory model
`timescale 1ns/1ps
module tb_bus_slave_port;
  localparam int RD_WAIT = 4;
`ifdef SLAVE_RD_WAIT_EN
  localparam int LAT = 2 + RD_WAIT;
  localparam int GAP = 1 + RD_WAIT;
`else
  localparam int LAT = 2;
  localparam int GAP = 1;
`endif
  logic clk = 0, rst;
  logic master_valid, master_ready, rx_address, rx_burst_num, rx_data, write_en, read_en;
  logic tx_data, slave_valid, slave_ready, trans_done;
  int n_checks = 0, n_fail = 0, cyc = 0, done_cnt = 0, last_addr_cyc = 0, fall_cyc = 0;
  int stall_mode = 0, mon_bit = 0;
  bit lat_pend = 0, prev_v = 0, prev_stall = 0, prev_done = 0;
  logic prev_tx;
  logic [7:0] mon_byte;
  logic [7:0] mem_m [2048];
  logic [7:0] wdat [8];
  logic [7:0] exp_q [$];
  bus_slave_port #(.ADDR_W(12), .MEM_ADDR_W(11), .DATA_W(8), .BURST_W(8), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .rst(rst), .master_valid(master_valid), .master_ready(master_ready),
    .rx_address(rx_address), .rx_burst_num(rx_burst_num), .rx_data(rx_data),
    .write_en(write_en), .read_en(read_en), .tx_data(tx_data), .slave_valid(slave_valid),
    .slave_ready(slave_ready), .trans_done(trans_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      mon_bit = 0;
      prev_v = 0;
      prev_stall = 0;
      prev_done = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", slave_valid, 1);
        chk("hold_data", tx_data, prev_tx);
      end
      if (slave_valid && !prev_v) begin
        if (lat_pend) begin
          chk("rd_latency", cyc - last_addr_cyc, LAT);
          lat_pend = 0;
        end else chk("word_gap", cyc - fall_cyc, GAP);
      end
      if (!slave_valid && prev_v) fall_cyc = cyc;
      if (trans_done) begin
        done_cnt++;
        chk("done_pulse_width", prev_done, 0);
      end
      if (slave_valid && master_ready) begin
        mon_byte = {mon_byte[6:0], tx_data};
        mon_bit++;
        if (mon_bit == 8) begin
          mon_bit = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_word: got %0h expected no word", mon_byte);
          end else chk("rd_word", mon_byte, exp_q.pop_front());
        end
      end
      prev_v = slave_valid;
      prev_stall = slave_valid && !master_ready;
      prev_tx = tx_data;
      prev_done = trans_done;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic stall(input int pos);
    int k;
    k = stall_mode == 1 ? ($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0) :
        (stall_mode == 2 && pos == 5) ? 3 : 0;
    repeat (k) begin
      master_valid = 0;
      rx_address = 1'($urandom);
      rx_data = 1'($urandom);
      tick();
    end
  endtask
  task automatic wait_ready();
    for (int t = 0; t < 100 && !slave_ready; t++) tick();
    chk("ready_timeout", slave_ready, 1);
  endtask
  task automatic send_addr(input logic [11:0] a, input logic [7:0] n, input bit wr);
    wait_ready();
    master_valid = 1;
    write_en = wr;
    read_en = !wr;
    rx_address = a[11];
    rx_burst_num = n[7];
    tick();
    write_en = 0;
    read_en = 0;
    for (int i = 1; i < 12; i++) begin
      stall(i);
      master_valid = 1;
      rx_address = a[11-i];
      rx_burst_num = i < 8 ? n[7-i] : 1'b0;
      tick();
    end
    master_valid = 0;
    last_addr_cyc = cyc;
    if (!wr) lat_pend = 1;
  endtask
  task automatic do_write(input logic [11:0] a, input logic [7:0] n, input int abort_at);
    int nw = n == 0 ? 1 : int'(n);
    int d0 = done_cnt;
    int b = 0;
    send_addr(a, n, 1);
    wait_ready();
    for (int w = 0; w < nw; w++)
      for (int i = 7; i >= 0; i--) begin
        if (b == abort_at) begin
          master_valid = 0;
          rst = 0;
          tick();
          rst = 1;
          tick();
          return;
        end
        stall(b % 8);
        master_valid = 1;
        rx_data = wdat[w][i];
        tick();
        b++;
      end
    master_valid = 0;
    for (int t = 0; t < 300 && done_cnt == d0; t++) tick();
    chk("wr_done", done_cnt - d0, 1);
    for (int w = 0; w < nw; w++) mem_m[(int'(a[10:0]) + w) % 2048] = wdat[w];
  endtask
  task automatic do_read(input logic [11:0] a, input logic [7:0] n, input int mode);
    int nw = n == 0 ? 1 : int'(n);
    int d0 = done_cnt;
    int held = 0;
    for (int w = 0; w < nw; w++) exp_q.push_back(mem_m[(int'(a[10:0]) + w) % 2048]);
    send_addr(a, n, 0);
    for (int t = 0; t < 800 && done_cnt == d0; t++) begin
      master_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 2) != 0) :
                     !(mon_bit == 3 && held < 5 && slave_valid);
      if (mode == 2 && !master_ready) held++;
      tick();
    end
    master_ready = 0;
    chk("rd_done", done_cnt - d0, 1);
    chk("rd_words_left", exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int d0;
    rst = 0;
    master_valid = 0;
    master_ready = 0;
    rx_address = 0;
    rx_burst_num = 0;
    rx_data = 0;
    write_en = 0;
    read_en = 0;
    repeat (3) tick();
    chk("rst_tx_data", tx_data, 0);
    chk("rst_slave_valid", slave_valid, 0);
    chk("rst_slave_ready", slave_ready, 0);
    chk("rst_trans_done", trans_done, 0);
    rst = 1;
    chk("ready_before_edge", slave_ready, 0);
    tick();
    chk("ready_after_release", slave_ready, 1);
    master_valid = 1;
    write_en = 1;
    rx_address = 1;
    tick();
    write_en = 0;
    repeat (4) tick();
    master_valid = 0;
    chk("addr_ready_low", slave_ready, 0);
    rst = 0;
    #2;
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_slave_valid", slave_valid, 0);
    chk("midrst_slave_ready", slave_ready, 0);
    chk("midrst_trans_done", trans_done, 0);
    @(posedge clk);
    #1;
    rst = 1;
    tick();
    chk("midrst_ready_release", slave_ready, 1);
    wdat[0] = 8'hA5;
    do_write(12'h005, 1, -1);
    do_read(12'h005, 1, 0);
    wdat[0] = 8'h11;
    wdat[1] = 8'h22;
    wdat[2] = 8'h33;
    do_write(12'h7FF, 3, -1);
    do_read(12'h7FF, 3, 0);
    do_read(12'h000, 2, 0);
    do_read(12'h7FF, 3, 2);
    stall_mode = 2;
    wdat[0] = 8'h3C;
    do_write(12'h100, 1, -1);
    do_read(12'h100, 1, 0);
    d0 = done_cnt;
    master_valid = 1;
    write_en = 1;
    read_en = 1;
    repeat (3) tick();
    master_valid = 0;
    write_en = 0;
    read_en = 0;
    repeat (3) tick();
    chk("illegal_ready", slave_ready, 1);
    chk("illegal_done", done_cnt - d0, 0);
    stall_mode = 0;
    wdat[0] = 8'hC3;
    do_write(12'h100, 1, 5);
    do_read(12'h100, 1, 0);
    do_read(12'h005, 0, 0);
    stall_mode = 1;
    for (int it = 0; it < 20; it++) begin
      logic [11:0] a;
      logic [7:0] n;
      a = 12'($urandom);
      n = 8'($urandom_range(0, 4));
      for (int w = 0; w < 8; w++) wdat[w] = 8'($urandom);
      do_write(a, n, -1);
      do_read(a, n, int'($urandom_range(0, 2)));
    end
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
